uart_tx_framed: RTL and testbench

Parametrised UART transmitter, the successor to the fixed 8N1 transmitter. It adds:
- configurable data width;
- runtime-selectable parity (none/even/odd) and stop bits (1 or 2);
- a runtime baud divisor;
- a small input FIFO so the host can queue characters.

It sits between a ready/valid byte producer and the serial TX pin.

---
 rtl/uart_tx_framed_if.sv | 11 +
 rtl/uart_tx_framed.sv | 235 +++++++++++++++++++++++
 tb/tb_uart_tx_framed.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_framed_if.sv
// Character handshake between a ready/valid producer and the framed UART transmitter.
interface uart_tx_framed_if #(
    parameter int DataBits = 8
);
    logic [DataBits-1:0] DataIn;
    logic                DataInValid;
    logic                DataInReady;

    modport master (output DataIn, output DataInValid, input DataInReady);
    modport slave  (input DataIn, input DataInValid, output DataInReady);
endinterface

// File: rtl/uart_tx_framed.sv
// Parametrised UART transmitter: small input FIFO, runtime parity/stop/baud settings,
// back-to-back frames when characters are queued.
module uart_tx_framed #(
    parameter int DataBits     = 8,
    parameter int FifoDepth    = 4,
    parameter int DivisorWidth = 16
) (
    input  logic                       Clock,
    input  logic                       Reset,
    uart_tx_framed_if.slave            DataPort,
    input  logic [DivisorWidth-1:0]    Divisor,
    input  logic                       ParityEn,
    input  logic                       ParityOdd,
    input  logic                       TwoStop,
    output logic                       SOut,
    output logic                       Busy,
    output logic [$clog2(FifoDepth):0] FifoCount
);
    localparam int PtrW = $clog2(FifoDepth);
    localparam int CntW = PtrW + 1;
    localparam int BitW = $clog2(DataBits + 1);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } state_t;

    function automatic logic parityOf(input logic [DataBits-1:0] d);
        return ^d;
    endfunction

    logic [DataBits-1:0]     fifoMem_r [FifoDepth];
    logic [PtrW-1:0]         wrPtr_r;
    logic [PtrW-1:0]         rdPtr_r;
    logic [CntW-1:0]         count_r;
    logic                    live_r;
    logic                    push_s;
    logic                    pop_s;
    logic                    empty_s;
    logic                    full_s;
    logic [DataBits-1:0]     head_s;

    state_t                  state_r;
    state_t                  stateNext_s;
    logic [DivisorWidth-1:0] cycleCnt_r;
    logic [DivisorWidth-1:0] cycleNext_s;
    logic [BitW-1:0]         bitCnt_r;
    logic [BitW-1:0]         bitNext_s;
    logic [DataBits-1:0]     shiftReg_r;
    logic [DataBits-1:0]     shiftNext_s;
    logic                    sOut_r;
    logic                    sOutNext_s;
    logic                    bitEnd_s;

    logic [DivisorWidth-1:0] divEff_r;
    logic                    parEn_r;
    logic                    parBit_r;
    logic                    twoStop_r;

    assign empty_s = (count_r == CntW'(0));
    assign full_s  = (count_r == CntW'(FifoDepth));
    assign head_s  = fifoMem_r[rdPtr_r];
    assign push_s  = DataPort.DataInValid && DataPort.DataInReady;

    // live_r holds ready low until the first edge that sees Reset released
    assign DataPort.DataInReady = live_r && !full_s;
    assign SOut      = sOut_r;
    assign Busy      = (state_r != StIdle) || !empty_s;
    assign FifoCount = count_r;
    assign bitEnd_s  = (cycleCnt_r == (divEff_r - DivisorWidth'(1)));

    // FIFO storage array, written on accepted handshakes
    always_ff @(posedge Clock) begin
        if (push_s) begin
            fifoMem_r[wrPtr_r] <= DataPort.DataIn;
        end
    end

    // FIFO pointers, occupancy and ready enable
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            wrPtr_r <= PtrW'(0);
            rdPtr_r <= PtrW'(0);
            count_r <= CntW'(0);
            live_r  <= 1'b0;
        end else begin
            live_r <= 1'b1;
            if (push_s) begin
                wrPtr_r <= wrPtr_r + PtrW'(1);
            end
            if (pop_s) begin
                rdPtr_r <= rdPtr_r + PtrW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CntW'(1);
                2'b01:   count_r <= count_r - CntW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Frame sequencing: next state, counters, shifter and next line level
    always_comb begin
        stateNext_s = state_r;
        pop_s       = 1'b0;
        sOutNext_s  = sOut_r;
        cycleNext_s = cycleCnt_r + DivisorWidth'(1);
        bitNext_s   = bitCnt_r;
        shiftNext_s = shiftReg_r;
        case (state_r)
            StIdle: begin
                cycleNext_s = DivisorWidth'(0);
                bitNext_s   = BitW'(0);
                if (!empty_s) begin
                    pop_s       = 1'b1;
                    stateNext_s = StStart;
                    sOutNext_s  = 1'b0;
                    shiftNext_s = head_s;
                end else begin
                    stateNext_s = StIdle;
                    sOutNext_s  = 1'b1;
                end
            end
            StStart: begin
                if (bitEnd_s) begin
                    stateNext_s = StData;
                    cycleNext_s = DivisorWidth'(0);
                    bitNext_s   = BitW'(0);
                    sOutNext_s  = shiftReg_r[0];
                end else begin
                    stateNext_s = StStart;
                end
            end
            StData: begin
                if (bitEnd_s) begin
                    cycleNext_s = DivisorWidth'(0);
                    if (bitCnt_r == BitW'(DataBits - 1)) begin
                        bitNext_s = BitW'(0);
                        if (parEn_r) begin
                            stateNext_s = StParity;
                            sOutNext_s  = parBit_r;
                        end else begin
                            stateNext_s = StStop;
                            sOutNext_s  = 1'b1;
                        end
                    end else begin
                        bitNext_s   = bitCnt_r + BitW'(1);
                        shiftNext_s = {1'b0, shiftReg_r[DataBits-1:1]};
                        sOutNext_s  = shiftReg_r[1];
                    end
                end else begin
                    stateNext_s = StData;
                end
            end
            StParity: begin
                if (bitEnd_s) begin
                    stateNext_s = StStop;
                    cycleNext_s = DivisorWidth'(0);
                    bitNext_s   = BitW'(0);
                    sOutNext_s  = 1'b1;
                end else begin
                    stateNext_s = StParity;
                end
            end
            StStop: begin
                if (bitEnd_s) begin
                    cycleNext_s = DivisorWidth'(0);
                    if (twoStop_r && (bitCnt_r == BitW'(0))) begin
                        bitNext_s  = BitW'(1);
                        sOutNext_s = 1'b1;
                    end else if (!empty_s) begin
                        // chain straight into the next start bit, no idle gap
                        pop_s       = 1'b1;
                        stateNext_s = StStart;
                        bitNext_s   = BitW'(0);
                        sOutNext_s  = 1'b0;
                        shiftNext_s = head_s;
                    end else begin
                        stateNext_s = StIdle;
                        bitNext_s   = BitW'(0);
                        sOutNext_s  = 1'b1;
                    end
                end else begin
                    stateNext_s = StStop;
                end
            end
            default: begin
                stateNext_s = StIdle;
                cycleNext_s = DivisorWidth'(0);
                bitNext_s   = BitW'(0);
                sOutNext_s  = 1'b1;
            end
        endcase
    end

    // FSM state, counters, shift register and line flop
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_r    <= StIdle;
            cycleCnt_r <= DivisorWidth'(0);
            bitCnt_r   <= BitW'(0);
            shiftReg_r <= DataBits'(0);
            sOut_r     <= 1'b1;
        end else begin
            state_r    <= stateNext_s;
            cycleCnt_r <= cycleNext_s;
            bitCnt_r   <= bitNext_s;
            shiftReg_r <= shiftNext_s;
            sOut_r     <= sOutNext_s;
        end
    end

    // Per-frame configuration shadow, captured as each character is popped
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            divEff_r  <= DivisorWidth'(2);
            parEn_r   <= 1'b0;
            parBit_r  <= 1'b0;
            twoStop_r <= 1'b0;
        end else if (pop_s) begin
            divEff_r  <= (Divisor < DivisorWidth'(2)) ? DivisorWidth'(2) : Divisor;
            parEn_r   <= ParityEn;
            parBit_r  <= parityOf(head_s) ^ ParityOdd;
            twoStop_r <= TwoStop;
        end else begin
            divEff_r  <= divEff_r;
            parEn_r   <= parEn_r;
            parBit_r  <= parBit_r;
            twoStop_r <= twoStop_r;
        end
    end
endmodule

// File: tb/tb_uart_tx_framed.sv
// Randomised scoreboard bench: a line monitor decodes every frame against a reference built
// from queued characters, plus directed timing checks on reset, latency, FIFO and aborts.
module tb_uart_tx_framed;
    localparam int DW = 16;

    logic Clock = 1'b0;
    logic Reset;
    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    uart_tx_framed_if #(.DataBits(8)) dataIf ();
    logic [DW-1:0] Divisor;
    logic ParityEn, ParityOdd, TwoStop, SOut, Busy;
    logic [2:0] FifoCount;

    uart_tx_framed #(.DataBits(8), .FifoDepth(4), .DivisorWidth(DW)) dut (
        .Clock(Clock), .Reset(Reset), .DataPort(dataIf.slave), .Divisor(Divisor),
        .ParityEn(ParityEn), .ParityOdd(ParityOdd), .TwoStop(TwoStop),
        .SOut(SOut), .Busy(Busy), .FifoCount(FifoCount)
    );

    uart_tx_framed_if #(.DataBits(7)) dataIf7 ();
    logic [DW-1:0] Divisor7;
    logic ParityEn7, ParityOdd7, TwoStop7, SOut7, Busy7;
    logic [2:0] FifoCount7;

    uart_tx_framed #(.DataBits(7), .FifoDepth(4), .DivisorWidth(DW)) dut7 (
        .Clock(Clock), .Reset(Reset), .DataPort(dataIf7.slave), .Divisor(Divisor7),
        .ParityEn(ParityEn7), .ParityOdd(ParityOdd7), .TwoStop(TwoStop7),
        .SOut(SOut7), .Busy(Busy7), .FifoCount(FifoCount7)
    );

    typedef struct {
        logic [7:0] data;
        int         div;
        bit         par;
        bit         odd;
        bit         two;
    } exp_t;

    exp_t sbq[$];
    int   startCyc[$];
    int   nTests = 0;
    int   nFail = 0;
    bit   abortFrame = 1'b0;

    function automatic int effDiv(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    function automatic int frameLen(input exp_t e);
        return (10 + int'(e.par) + int'(e.two)) * effDiv(e.div);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Line monitor: each falling edge opens a frame matched against the scoreboard head
    initial begin : monitor
        bit prevS;
        bit bits[$];
        exp_t e;
        int d, n, bad, firstBad;
        bit aborted;
        prevS = 1'b1;
        forever begin
            @(negedge Clock);
            if (!abortFrame && Reset === 1'b1 && prevS && SOut === 1'b0) begin
                if (sbq.size() == 0) begin
                    nTests++;
                    nFail++;
                    $display("FAIL unexpected_frame: start bit at cycle %0d with nothing queued", cyc);
                    prevS = 1'b0;
                end else begin
                    e = sbq.pop_front();
                    startCyc.push_back(cyc);
                    bits.delete();
                    bits.push_back(1'b0);
                    for (int i = 0; i < 8; i++) bits.push_back(e.data[i]);
                    if (e.par) bits.push_back(($countones(e.data) % 2 == 1) ^ e.odd);
                    bits.push_back(1'b1);
                    if (e.two) bits.push_back(1'b1);
                    d = effDiv(e.div);
                    n = bits.size() * d;
                    bad = 0;
                    firstBad = -1;
                    aborted = 1'b0;
                    for (int k = 0; k < n; k++) begin
                        if (k > 0) @(negedge Clock);
                        if (abortFrame) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (SOut !== bits[k / d]) begin
                            bad++;
                            if (firstBad < 0) firstBad = k;
                        end
                    end
                    if (!aborted) begin
                        nTests++;
                        if (bad != 0) begin
                            nFail++;
                            $display("FAIL frame: data=%h div=%0d par=%0d odd=%0d two=%0d got %0d wrong cycles (first at %0d) expected 0",
                                     e.data, d, e.par, e.odd, e.two, bad, firstBad);
                        end
                    end
                    prevS = (SOut === 1'b1);
                end
            end else begin
                prevS = (SOut === 1'b1);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic writeExp(input exp_t e);
        int n;
        @(negedge Clock);
        dataIf.DataIn = e.data;
        dataIf.DataInValid = 1'b1;
        n = 0;
        while (dataIf.DataInReady !== 1'b1 && n < 3000) begin
            @(negedge Clock);
            n++;
        end
        if (dataIf.DataInReady !== 1'b1) begin
            nTests++;
            nFail++;
            $display("FAIL write_timeout: ready stayed %b, required 1", dataIf.DataInReady);
            dataIf.DataInValid = 1'b0;
        end else begin
            sbq.push_back(e);
            @(posedge Clock);
            #1 dataIf.DataInValid = 1'b0;
        end
    endtask

    function automatic exp_t curCfg(input logic [7:0] data);
        exp_t e;
        e.data = data;
        e.div  = int'(Divisor);
        e.par  = ParityEn;
        e.odd  = ParityOdd;
        e.two  = TwoStop;
        return e;
    endfunction

    task automatic writeChar(input logic [7:0] data);
        writeExp(curCfg(data));
    endtask

    task automatic sendAndTime(input logic [7:0] data, input bit checkLat, input string name);
        int lat, t0, n;
        exp_t e;
        e = curCfg(data);
        writeExp(e);
        lat = 0;
        while (SOut !== 1'b0 && lat < 3000) begin
            @(negedge Clock);
            lat++;
        end
        if (checkLat) check({name, "_start_latency"}, lat, 2);
        t0 = cyc;
        n = 0;
        while (Busy !== 1'b0 && n < 5000) begin
            @(negedge Clock);
            n++;
        end
        check({name, "_frame_cycles"}, cyc - t0, frameLen(e));
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((sbq.size() != 0 || Busy !== 1'b0) && n < 20000) begin
            @(negedge Clock);
            n++;
        end
        @(negedge Clock);
        check("drain_busy", int'(Busy), 0);
    endtask

    initial begin : stim
        int acc, n, lowCnt, nb;
        int pat7[10];
        bit bad7;
        exp_t e;
        pat7 = '{0, 1, 0, 0, 0, 0, 0, 1, 1, 1};
        Reset = 1'b0;
        dataIf.DataIn = 8'h00;
        dataIf.DataInValid = 1'b0;
        Divisor = 16'd4;
        ParityEn = 1'b0;
        ParityOdd = 1'b0;
        TwoStop = 1'b0;
        dataIf7.DataIn = 7'h00;
        dataIf7.DataInValid = 1'b0;
        Divisor7 = 16'd3;
        ParityEn7 = 1'b0;
        ParityOdd7 = 1'b0;
        TwoStop7 = 1'b1;

        repeat (3) @(negedge Clock);
        check("reset_sout", int'(SOut), 1);
        check("reset_ready", int'(dataIf.DataInReady), 0);
        check("reset_busy", int'(Busy), 0);
        check("reset_count", int'(FifoCount), 0);
        Reset = 1'b1;
        #1 check("ready_before_release_edge", int'(dataIf.DataInReady), 0);
        @(negedge Clock);
        check("ready_after_release_edge", int'(dataIf.DataInReady), 1);

        // 8N1 at divisor 4
        Divisor = 16'd4;
        sendAndTime(8'h55, 1'b1, "basic_55");

        // even then odd parity at divisor 2
        Divisor = 16'd2;
        ParityEn = 1'b1;
        ParityOdd = 1'b0;
        sendAndTime(8'h07, 1'b0, "parity_even");
        ParityOdd = 1'b1;
        sendAndTime(8'h07, 1'b0, "parity_odd");
        ParityEn = 1'b0;
        ParityOdd = 1'b0;

        // 7-bit data with two stop bits on the second instance
        @(negedge Clock);
        dataIf7.DataIn = 7'h41;
        dataIf7.DataInValid = 1'b1;
        @(posedge Clock);
        #1 dataIf7.DataInValid = 1'b0;
        @(negedge Clock);
        check("dut7_idle_before_pop", int'(SOut7), 1);
        for (int b = 0; b < 10; b++) begin
            bad7 = 1'b0;
            for (int c = 0; c < 3; c++) begin
                @(negedge Clock);
                if (SOut7 !== pat7[b][0]) bad7 = 1'b1;
            end
            nTests++;
            if (bad7) begin
                nFail++;
                $display("FAIL dut7_bit%0d: line did not hold %0d for 3 cycles", b, pat7[b]);
            end
        end
        @(negedge Clock);
        check("dut7_busy_after_frame", int'(Busy7), 0);

        // FIFO fill: ten offered, five accepted
        Divisor = 16'd8;
        startCyc.delete();
        acc = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge Clock);
            dataIf.DataIn = 8'(i);
            dataIf.DataInValid = 1'b1;
            if (dataIf.DataInReady === 1'b1) begin
                acc++;
                sbq.push_back(curCfg(8'(i)));
            end
        end
        @(posedge Clock);
        #1 dataIf.DataInValid = 1'b0;
        @(negedge Clock);
        check("fill_accepted", acc, 5);
        check("fill_count", int'(FifoCount), 4);
        check("fill_ready_low", int'(dataIf.DataInReady), 0);
        n = 0;
        while (dataIf.DataInReady !== 1'b1 && n < 1000) begin
            @(negedge Clock);
            n++;
        end
        check("fill_ready_at_second_pop", (startCyc.size() > 0) ? cyc - startCyc[0] : -1, 80);
        waitDrain();
        check("fill_frames_seen", startCyc.size(), 5);
        for (int k = 1; k < startCyc.size(); k++)
            check("fill_back_to_back", startCyc[k] - startCyc[k - 1], 80);

        // divisor 0 and 1 behave as 2
        Divisor = 16'd0;
        sendAndTime(8'hC3, 1'b0, "div0");
        Divisor = 16'd1;
        sendAndTime(8'h3A, 1'b0, "div1");

        // divisor change mid-frame applies only to the following frame
        Divisor = 16'd4;
        startCyc.delete();
        writeChar(8'hA5);
        e = curCfg(8'h3C);
        e.div = 8;
        writeExp(e);
        repeat (3) @(negedge Clock);
        Divisor = 16'd8;
        waitDrain();
        check("midchange_frames_seen", startCyc.size(), 2);
        if (startCyc.size() == 2) check("midchange_first_frame_cycles", startCyc[1] - startCyc[0], 40);

        // reset during DATA with two characters queued
        Divisor = 16'd4;
        writeChar(8'h00);
        writeChar(8'hFF);
        writeChar(8'h81);
        repeat (10) @(negedge Clock);
        abortFrame = 1'b1;
        Reset = 1'b0;
        @(negedge Clock);
        Reset = 1'b1;
        check("abort_sout", int'(SOut), 1);
        check("abort_count", int'(FifoCount), 0);
        check("abort_busy", int'(Busy), 0);
        sbq.delete();
        @(negedge Clock);
        abortFrame = 1'b0;
        lowCnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clock);
            if (SOut !== 1'b1) lowCnt++;
        end
        check("abort_no_more_frames", lowCnt, 0);
        sendAndTime(8'h5A, 1'b1, "after_abort");

        // randomised batches, configuration fixed within each batch
        for (int b = 0; b < 8; b++) begin
            Divisor = 16'($urandom_range(0, 5));
            ParityEn = 1'($urandom_range(0, 1));
            ParityOdd = 1'($urandom_range(0, 1));
            TwoStop = 1'($urandom_range(0, 1));
            nb = $urandom_range(1, 4);
            for (int j = 0; j < nb; j++) begin
                writeChar(8'($urandom));
                repeat ($urandom_range(0, 3)) @(negedge Clock);
            end
            waitDrain();
        end

        check("scoreboard_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
